scytale_cipher_engine: RTL and testbench

- Parametrised successor to the single-mode scytale decryption block.
- Buffers one message, then streams it out in either decrypt (column-major) or encrypt (row-major) order.
- Adds an explicit FSM, output backpressure (valid/ready), an input-ready flag, a done pulse and overflow handling.
- Sits between the byte-stream demux and the decryption output mux, alongside the other cipher engines.

---
 rtl/scytale_pkg.sv | 17 +
 rtl/scytale_addr_gen.sv | 61 ++++++
 rtl/scytale_cipher_engine.sv | 150 +++++++++++++++
 tb/tb_scytale_cipher_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scytale_pkg.sv
// Shared types and helpers for the scytale cipher engine.
package scytale_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_DECRYPT = 1'b0;
  localparam logic MODE_ENCRYPT = 1'b1;

  function automatic int idx_width(input int max_chars);
    return $clog2(max_chars + 1);
  endfunction

endpackage

// File: rtl/scytale_addr_gen.sv
// Read-address walker: visits k = start, start+S, ... then moves to the next start column.
module scytale_addr_gen
  import scytale_pkg::*;
#(
  parameter int IW        = 6,
  parameter int KEY_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IW-1:0]        n_i,
  input  logic [KEY_WIDTH-1:0] stride_i,
  input  logic                 advance_i,
  input  logic                 load_i,
  output logic [IW-1:0]        k_o,
  output logic                 last_o
);

  // One bit wider than either operand so k+S never wraps.
  localparam int CW = ((IW > KEY_WIDTH) ? IW : KEY_WIDTH) + 1;

  logic [IW-1:0] start_q, start_d;
  logic [IW-1:0] k_q, k_d;
  logic [CW-1:0] n_ext, s_ext, k_step, start_inc;
  logic          step_ok, next_col_ok;

  assign n_ext       = CW'(n_i);
  assign s_ext       = CW'(stride_i);
  assign k_step      = CW'(k_q) + s_ext;
  assign start_inc   = CW'(start_q) + CW'(1);
  assign step_ok     = (k_step < n_ext);
  assign next_col_ok = (start_inc < s_ext) && (start_inc < n_ext);
  assign last_o      = !step_ok && !next_col_ok;
  assign k_o         = k_q;

  always_comb begin
    start_d = start_q;
    k_d     = k_q;
    if (load_i) begin
      start_d = '0;
      k_d     = '0;
    end else if (advance_i) begin
      if (step_ok) begin
        k_d = k_step[IW-1:0];
      end else if (next_col_ok) begin
        start_d = start_inc[IW-1:0];
        k_d     = start_inc[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      k_q     <= '0;
    end else begin
      start_q <= start_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: rtl/scytale_cipher_engine.sv
// Scytale engine: capture a message, emit it column-major (decrypt) or row-major (encrypt).
// Optional SCYTALE_KEY_CHECK_EN rejects messages whose length is not key_N*key_M (err_o).
module scytale_cipher_engine
  import scytale_pkg::*;
#(
  parameter int                 D_WIDTH       = 8,
  parameter int                 KEY_WIDTH     = 8,
  parameter int                 MAX_NOF_CHARS = 50,
  parameter logic [D_WIDTH-1:0] START_TOKEN   = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 mode_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 done_o,
  output logic                 overflow_o,
  output state_t               state_dbg_o
`ifdef SCYTALE_KEY_CHECK_EN
  ,
  output logic                 err_o
`endif
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // data is held stable while valid is high and ready is low.

  localparam int IW = idx_width(MAX_NOF_CHARS);

  state_t               state_q;
  logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];
  logic [IW-1:0]        n_q;
  logic [KEY_WIDTH-1:0] stride_q;
  logic                 busy_q, valid_q, done_q, ovf_q, cap_ovf_q;
  logic [KEY_WIDTH-1:0] stride_sel;
  logic                 token_w, advance_w, load_w, empty_w, last_w;
  logic [IW-1:0]        k_w;

  assign stride_sel = (mode_i == MODE_ENCRYPT) ? key_M : key_N;
  assign token_w    = (state_q == ST_IDLE) && valid_i && (data_i == START_TOKEN);
  assign advance_w  = (state_q == ST_EMIT) && ready_i;
  assign load_w     = token_w || (state_q == ST_DONE);

`ifdef SCYTALE_KEY_CHECK_EN
  localparam int PW = ((2 * KEY_WIDTH) > IW) ? (2 * KEY_WIDTH) : IW;
  logic [PW-1:0] key_prod;
  logic          key_bad;
  logic          err_q;
  assign key_prod = PW'(key_N) * PW'(key_M);
  assign key_bad  = (PW'(n_q) != key_prod) || (key_N == '0) || (key_M == '0);
  assign empty_w  = (n_q == '0) || (stride_sel == '0) || key_bad;
  assign err_o    = err_q;
`else
  assign empty_w  = (n_q == '0) || (stride_sel == '0);
`endif

  scytale_addr_gen #(
    .IW        (IW),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .n_i       (n_q),
    .stride_i  (stride_q),
    .advance_i (advance_w),
    .load_i    (load_w),
    .k_o       (k_w),
    .last_o    (last_w)
  );

  assign ready_o     = (state_q == ST_IDLE);
  assign busy        = busy_q;
  assign valid_o     = valid_q;
  assign data_o      = valid_q ? buf_q[k_w] : '0;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
  assign state_dbg_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      stride_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cap_ovf_q <= 1'b0;
`ifdef SCYTALE_KEY_CHECK_EN
      err_q     <= 1'b0;
`endif
      for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (data_i == START_TOKEN) begin
              stride_q <= stride_sel;
              // A token clears the sticky flag unless this very message overflowed.
              ovf_q    <= cap_ovf_q;
              if (empty_w) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
`ifdef SCYTALE_KEY_CHECK_EN
                err_q   <= key_bad;
`endif
              end else begin
                state_q <= ST_EMIT;
                busy_q  <= 1'b1;
                valid_q <= 1'b1;
              end
            end else if (n_q == IW'(MAX_NOF_CHARS)) begin
              ovf_q     <= 1'b1;
              cap_ovf_q <= 1'b1;
            end else begin
              buf_q[n_q] <= data_i;
              n_q        <= n_q + IW'(1);
            end
          end
        end
        ST_EMIT: begin
          if (ready_i && last_w) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          done_q    <= 1'b0;
          n_q       <= '0;
          cap_ovf_q <= 1'b0;
`ifdef SCYTALE_KEY_CHECK_EN
          err_q     <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scytale_cipher_engine.sv
// Scoreboard bench for scytale_cipher_engine: expected beats queued at drive time, popped on transfer.
module tb_scytale_cipher_engine;
  import scytale_pkg::*;

  localparam int DW   = 8;
  localparam int KW   = 8;
  localparam int MAXC = 50;
  localparam logic [DW-1:0] TOK = 8'hFA;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic          mode_i;
  logic [KW-1:0] key_N, key_M;
  logic          busy;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          done_o;
  logic          overflow_o;
  state_t        state_dbg;
`ifdef SCYTALE_KEY_CHECK_EN
  logic          err_o;
`endif

  always #5 clk = ~clk;

  scytale_cipher_engine #(
    .D_WIDTH(DW), .KEY_WIDTH(KW), .MAX_NOF_CHARS(MAXC), .START_TOKEN(TOK)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .key_N(key_N), .key_M(key_M), .busy(busy), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .done_o(done_o), .overflow_o(overflow_o),
    .state_dbg_o(state_dbg)
`ifdef SCYTALE_KEY_CHECK_EN
    , .err_o(err_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] msg_q[$];
  logic [DW-1:0] out_q[$];

  int cyc = 0;
  int beat_cnt = 0;
  int first_beat_cyc = 0, last_beat_cyc = 0, tok_cyc = 0, drive_cyc = 0;
  logic want_first = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int rdy_mode = 0;
  int rdy_phase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always high, or the pattern 1,0,0,1,0,0,...
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) ready_i = 1'b1;
    else begin
      ready_i = (rdy_phase % 3 == 0);
      rdy_phase++;
    end
  end

  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        check_eq("hold_valid", valid_o, 1);
        check_eq("hold_data", data_o, stall_data);
      end
      stall_prev = 1'b0;
      if (valid_o) begin
        if (want_first) begin
          first_beat_cyc = cyc;
          want_first = 1'b0;
        end
        if (ready_i) begin
          beat_cnt++;
          last_beat_cyc = cyc;
          out_q.push_back(data_o);
          check_eq("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_eq("beat_data", data_o, exp_q.pop_front());
        end else begin
          stall_prev = 1'b1;
          stall_data = data_o;
        end
      end
    end
  end

  // Caller is positioned at posedge+1; returns at posedge+1 after the char was sampled.
  task automatic drive_char(input logic [DW-1:0] c);
    int guard = 0;
    while (!ready_o && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard == 200) check_eq("ready_timeout", ready_o, 1);
    drive_cyc = cyc;
    data_i  = c;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic push_model(input int s, input int n);
    for (int st = 0; st < s && st < n; st++)
      for (int k = st; k < n; k += s) exp_q.push_back(msg_q[k]);
  endtask

  task automatic run_msg(input logic mode, input int kn, input int km, input int exp_beats,
                         input logic exp_err, input logic ovf_pre, input logic ovf_post);
    int b0 = beat_cnt;
    int guard = 0;
    int done_cyc = 0;
    logic seen = 1'b0;
    logic err_seen = 1'b0;
    foreach (msg_q[i]) drive_char(msg_q[i]);
    check_eq("ovf_pre", overflow_o, ovf_pre);
    mode_i = mode;
    key_N  = KW'(kn);
    key_M  = KW'(km);
    want_first = 1'b1;
    drive_char(TOK);
    tok_cyc = drive_cyc;
    key_N  = KW'($urandom_range(0, 255));
    key_M  = KW'($urandom_range(0, 255));
    mode_i = 1'($urandom_range(0, 1));
    while (!seen && guard < 2000) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        done_cyc = cyc;
`ifdef SCYTALE_KEY_CHECK_EN
        err_seen = err_o;
`endif
      end
      guard++;
    end
    check_eq("done_seen", seen, 1);
    check_eq("busy_done", busy, 0);
    check_eq("valid_done", valid_o, 0);
    if (exp_beats > 0) begin
      check_eq("first_lat", first_beat_cyc - tok_cyc, 1);
      check_eq("done_lat", done_cyc - last_beat_cyc, 1);
    end else begin
      check_eq("empty_done_lat", done_cyc - tok_cyc, 1);
    end
    check_eq("beats", beat_cnt - b0, exp_beats);
    check_eq("exp_left", exp_q.size(), 0);
    check_eq("ovf_post", overflow_o, ovf_post);
`ifdef SCYTALE_KEY_CHECK_EN
    check_eq("err", err_seen, exp_err);
`else
    if (exp_err) $display("note: key error expected only with key check enabled");
`endif
    want_first = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic load_seq(input logic [DW-1:0] first, input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(first + DW'(i));
  endtask

  task automatic push_list(input logic [47:0] packed_bytes, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(packed_bytes[i*8 +: 8]);
  endtask

  logic kc;

  initial begin
`ifdef SCYTALE_KEY_CHECK_EN
    kc = 1'b1;
`else
    kc = 1'b0;
`endif
    rst = 1'b1; valid_i = 1'b0; data_i = '0; mode_i = 1'b0; key_N = '0; key_M = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_ready", ready_o, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Decrypt 2x3.
    load_seq(8'h41, 6);
    push_list(48'h41_43_45_42_44_46, 6);
    run_msg(MODE_DECRYPT, 2, 3, 6, 0, 0, 0);

    // Encrypt 2x3, then feed the ciphertext back through decrypt.
    out_q.delete();
    load_seq(8'h41, 6);
    push_list(48'h41_44_42_45_43_46, 6);
    run_msg(MODE_ENCRYPT, 2, 3, 6, 0, 0, 0);
    msg_q = out_q;
    push_list(48'h41_42_43_44_45_46, 6);
    run_msg(MODE_DECRYPT, 2, 3, 6, 0, 0, 0);

    // Backpressure.
    rdy_mode = 1; rdy_phase = 0;
    load_seq(8'h41, 6);
    push_list(48'h41_43_45_42_44_46, 6);
    run_msg(MODE_DECRYPT, 2, 3, 6, 0, 0, 0);
    rdy_mode = 0;

    // Partial column: 7 chars, stride 3.
    load_seq(8'h30, 7);
    if (kc) run_msg(MODE_DECRYPT, 3, 3, 0, 1, 0, 0);
    else begin
      push_list(48'h30_33_36_31_34_32, 6);
      exp_q.push_back(8'h35);
      run_msg(MODE_DECRYPT, 3, 3, 7, 0, 0, 0);
    end

    // Overflow: 51 chars, only the first 50 are kept.
    msg_q.delete();
    for (int i = 0; i < MAXC + 1; i++) msg_q.push_back(DW'($urandom_range(0, 8'hF9)));
    push_model(5, MAXC);
    run_msg(MODE_DECRYPT, 5, 10, MAXC, 0, 1, 1);

    // Token alone: flag still set before it, cleared by it.
    msg_q.delete();
    run_msg(MODE_DECRYPT, 2, 3, 0, kc, 1, 0);

    // Zero stride.
    load_seq(8'h50, 4);
    run_msg(MODE_DECRYPT, 0, 4, 0, kc, 0, 0);

    // Random shapes, random mode and backpressure.
    for (int t = 0; t < 8; t++) begin
      int kn, km, s;
      logic md;
      kn = $urandom_range(1, 7);
      km = $urandom_range(1, 7);
      md = 1'($urandom_range(0, 1));
      rdy_mode = $urandom_range(0, 1);
      msg_q.delete();
      for (int i = 0; i < kn * km; i++) msg_q.push_back(DW'($urandom_range(0, 8'hF9)));
      s = md ? km : kn;
      push_model(s, kn * km);
      run_msg(md, kn, km, kn * km, 0, 0, 0);
    end
    rdy_mode = 0;

    // Reset after the third beat.
    begin
      int b0, guard;
      load_seq(8'h41, 6);
      push_list(48'h41_43_45_42_44_46, 6);
      b0 = beat_cnt;
      foreach (msg_q[i]) drive_char(msg_q[i]);
      mode_i = MODE_DECRYPT; key_N = 8'd2; key_M = 8'd3;
      drive_char(TOK);
      guard = 0;
      while (beat_cnt - b0 < 3 && guard < 100) begin
        @(negedge clk); #1;
        guard++;
      end
      check_eq("beats_before_rst", beat_cnt - b0, 3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_valid", valid_o, 0);
      check_eq("mid_rst_data", data_o, 0);
      check_eq("mid_rst_ready", ready_o, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      load_seq(8'h41, 6);
      push_list(48'h41_43_45_42_44_46, 6);
      run_msg(MODE_DECRYPT, 2, 3, 6, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
